fp_mac_pipe: RTL

Parametrised, pipelined floating-point multiply-accumulate for dot products.
- Successor to the fixed fp16 MAC: generic exponent/mantissa widths, valid/ready handshakes, explicit vector framing (in_last), a term counter, and defined special-value handling.
- Sits between operand streaming logic and the result collector in the float_MAC datapath. Defaults give IEEE binary16.

---
 rtl/fp_mac_pipe.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/fp_mac_pipe.sv
// rtl/fp_mac_pipe.sv - pipelined FP multiply-accumulate: input reg, RNE multiply, single-cycle accumulate, FTZ.
// Optional FP_MAC_SATURATE_EN: overflow clamps to signed max finite instead of infinity.
module fp_mac_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int CNT_W = 8
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_acc,
  output logic [CNT_W-1:0]       out_count,
  output logic [2:0]             out_flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int M    = MAN_W + 1;
  localparam int E    = M + 3;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Returns {overflow, inexact, word}; e is the unbiased-plus-bias exponent before rounding.
  function automatic logic [W+1:0] round_pack(input logic s, input int e, input logic [MAN_W-1:0] f,
                                              input logic g, input logic st);
    logic [MAN_W:0] fr;
    int             er;
    logic [W-1:0]   word;
    logic           ovf, inx;
    fr  = {1'b0, f} + {{MAN_W{1'b0}}, g & (st | f[0])};
    er  = fr[MAN_W] ? e + 1 : e;
    inx = g | st;
    ovf = 1'b0;
    if (er >= EMAX) begin
      ovf = 1'b1;
      inx = 1'b1;
`ifdef FP_MAC_SATURATE_EN
      word = {s, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
`else
      word = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`endif
    end else if (er <= 0) begin
      word = {s, {(W-1){1'b0}}};
      inx  = 1'b1;
    end else begin
      word = {s, er[EXP_W-1:0], fr[MAN_W-1:0]};
    end
    return {ovf, inx, word};
  endfunction

  // Returns {nan, overflow, inexact, word}.
  function automatic logic [W+2:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
    int             ea, eb, e;
    logic           s, an, bn, ai, bi, az, bz;
    logic [2*M-1:0] prod;
    logic [W+2:0]   res;
    ea = int'(a[W-2:MAN_W]);
    eb = int'(b[W-2:MAN_W]);
    s  = a[W-1] ^ b[W-1];
    an = (ea == EMAX) && (a[MAN_W-1:0] != '0);
    bn = (eb == EMAX) && (b[MAN_W-1:0] != '0);
    ai = (ea == EMAX) && (a[MAN_W-1:0] == '0);
    bi = (eb == EMAX) && (b[MAN_W-1:0] == '0);
    az = (ea == 0);
    bz = (eb == 0);
    if (an || bn || (ai && bz) || (bi && az)) begin
      res = {3'b100, QNAN};
    end else if (ai || bi) begin
      res = {3'b000, s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (az || bz) begin
      res = {2'b00, (az && a[MAN_W-1:0] != '0) || (bz && b[MAN_W-1:0] != '0), s, {(W-1){1'b0}}};
    end else begin
      prod = {{M{1'b0}}, 1'b1, a[MAN_W-1:0]} * {{M{1'b0}}, 1'b1, b[MAN_W-1:0]};
      e    = ea + eb - BIAS;
      if (prod[2*M-1]) e = e + 1;
      else             prod = prod << 1;
      res = {1'b0, round_pack(s, e, prod[2*MAN_W -: MAN_W], prod[MAN_W], |prod[MAN_W-1:0])};
    end
    return res;
  endfunction

  function automatic logic [W+2:0] fadd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y;
    int           ex, ey, d, p, e;
    logic [E-1:0] mx, my;
    logic [E:0]   sm, n;
    logic         an, bn, ai, bi, az, bz, lost;
    logic [W+2:0] res;
    an = (a[W-2:MAN_W] == '1) && (a[MAN_W-1:0] != '0);
    bn = (b[W-2:MAN_W] == '1) && (b[MAN_W-1:0] != '0);
    ai = (a[W-2:MAN_W] == '1) && (a[MAN_W-1:0] == '0);
    bi = (b[W-2:MAN_W] == '1) && (b[MAN_W-1:0] == '0);
    az = (a[W-2:MAN_W] == '0);
    bz = (b[W-2:MAN_W] == '0);
    if (an || bn || (ai && bi && (a[W-1] != b[W-1]))) res = {3'b100, QNAN};
    else if (ai)       res = {3'b000, a};
    else if (bi)       res = {3'b000, b};
    else if (az && bz) res = {3'b000, a[W-1] & b[W-1], {(W-1){1'b0}}};
    else if (az)       res = {3'b000, b};
    else if (bz)       res = {3'b000, a};
    else begin
      if (a[W-2:0] >= b[W-2:0]) begin x = a; y = b; end
      else                      begin x = b; y = a; end
      ex   = int'(x[W-2:MAN_W]);
      ey   = int'(y[W-2:MAN_W]);
      d    = ex - ey;
      mx   = {1'b1, x[MAN_W-1:0], 3'b000};
      my   = {1'b1, y[MAN_W-1:0], 3'b000};
      lost = 1'b0;
      for (int i = 0; i < E; i++) if (i < d && my[i]) lost = 1'b1;
      my    = (d >= E) ? '0 : my >> d;
      my[0] = my[0] | lost;
      sm = (x[W-1] == y[W-1]) ? {1'b0, mx} + {1'b0, my} : {1'b0, mx} - {1'b0, my};
      if (sm == '0) begin
        res = {3'b000, {W{1'b0}}};
      end else begin
        p = 0;
        for (int i = 0; i <= E; i++) if (sm[i]) p = i;
        // Leading one lands on bit E-1; three guard bits keep rounding exact.
        if (p == E) begin
          n = (sm >> 1) | {{E{1'b0}}, sm[0]};
          e = ex + 1;
        end else begin
          n = sm << (E - 1 - p);
          e = ex - (E - 1 - p);
        end
        res = {1'b0, round_pack(x[W-1], e, n[E-2:3], n[2], n[1] | n[0])};
      end
    end
    return res;
  endfunction

  logic               s0_valid, s0_last, s1_valid, s1_last, stall;
  logic [W-1:0]       s0_a, s0_b, s1_p, acc;
  logic [2:0]         s1_flags, flg, flg_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [W+2:0]       mul_r, add_r;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign mul_r    = fmul(s0_a, s0_b);
  assign add_r    = fadd(acc, s1_p);
  assign cnt_nxt  = (&cnt) ? cnt : cnt + 1'b1;
  assign flg_nxt  = flg | s1_flags | add_r[W+2:W];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s0_valid <= 1'b0; s0_last <= 1'b0; s0_a <= '0; s0_b <= '0;
      s1_valid <= 1'b0; s1_last <= 1'b0; s1_p <= '0; s1_flags <= '0;
      acc <= '0; cnt <= '0; flg <= '0;
      out_valid <= 1'b0; out_acc <= '0; out_count <= '0; out_flags <= '0;
    end else if (!stall) begin
      s0_valid  <= in_valid;
      s0_last   <= in_last;
      s0_a      <= in_a;
      s0_b      <= in_b;
      s1_valid  <= s0_valid;
      s1_last   <= s0_last;
      s1_p      <= mul_r[W-1:0];
      s1_flags  <= mul_r[W+2:W];
      out_valid <= s1_valid && s1_last;
      if (s1_valid) begin
        if (s1_last) begin
          // Publish the finished sum and restart the next vector from +0.
          out_acc   <= add_r[W-1:0];
          out_count <= cnt_nxt;
          out_flags <= flg_nxt;
          acc <= '0; cnt <= '0; flg <= '0;
        end else begin
          acc <= add_r[W-1:0];
          cnt <= cnt_nxt;
          flg <= flg_nxt;
        end
      end
    end
  end

endmodule
